instr_fetch_unit: RTL and testbench
===================================

# instr_fetch_unit

Consumer side of the program counter: reads the current PC, fetches the 16-bit instruction word at that address from instruction memory, presents it to the decoder over a valid/ready handshake, and pulses `pc_enable` so the PC advances exactly once per accepted fetch. It sits between the program counter, the instruction memory port, and the decode stage of the 16-bit CPU.

## Interface
Parameters:
- `ADDR_W`, 16, width of the PC and the memory address.
- `DATA_W`, 16, width of the instruction word.

Ports:
- `clk` in 1: clock, rising edge.
- `reset` in 1: asynchronous, active-low reset.
- `run` in 1: fetch enable. When 0, the block finishes the current transaction and then stays idle.
- `flush` in 1: discards the current or in-flight instruction (branch or redirect).
- `pc_in` in ADDR_W: current PC value from the program counter.
- `pc_enable` out 1: PC increment strobe. Combinational, high for exactly one cycle per accepted fetch.
- `mem_req` out 1: memory read request.
- `mem_addr` out ADDR_W: read address. Registered, and stable while `mem_req` is high.
- `mem_ack` in 1: read data valid. Single-cycle pulse with arbitrary latency of 1 or more cycles after `mem_req` rises.
- `mem_rdata` in DATA_W: read data, sampled when `mem_ack` is high.
- `instr_out` out DATA_W: fetched instruction (registered).
- `instr_valid` out 1: `instr_out` is valid.
- `instr_ready` in 1: the decoder accepts the instruction.

## Operation
- Reset values: state = IDLE; `mem_req`, `instr_valid` and `discard` = 0; `mem_addr` and `instr_out` = 0. Because `pc_enable` is combinational, it is 0 in reset.
- **IDLE**
  - If `run` is 1 and `flush` is 0: latch `mem_addr <= pc_in`, set `mem_req <= 1`, and move to REQ.
  - Otherwise stay in IDLE.
- **REQ**
  - `mem_req` stays at 1 and `mem_addr` is held until `mem_ack`. A request is never withdrawn.
  - `flush` while in REQ (including in the ack cycle) sets `discard`.
  - On `mem_ack` with `discard` = 0 and `flush` = 0:
    - `instr_out <= mem_rdata`, `instr_valid <= 1`, `mem_req <= 0`.
    - `pc_enable` = 1 in this cycle.
    - Move to HOLD.
  - On `mem_ack` when `discard` or `flush` is set:
    - Drop the data and clear `discard`.
    - `pc_enable` stays 0.
    - `mem_req <= 0`, move to IDLE.
- **HOLD**
  - `instr_valid` = 1 and `instr_out` is stable.
  - `flush`: clear `instr_valid` and go to IDLE (`flush` wins over `instr_ready`). The PC has already advanced; the redirecting logic reloads it.
  - `instr_ready` with no `flush`: clear `instr_valid`.
    - If `run` is 1: latch `mem_addr <= pc_in` (now the incremented PC), `mem_req <= 1`, go to REQ.
    - If `run` is 0: go to IDLE.
- `pc_enable` = (state == REQ) & `mem_ack` & ~`discard` & ~`flush`. It is never asserted in IDLE or HOLD.
- `run` falling in REQ does not abort the transaction. The block completes the fetch, holds the instruction, then idles.
- Address arithmetic: none internally. The PC owns increment and wrap-around (0xFFFF to 0x0000). The fetch unit samples `pc_in` unmodified.
- Reset asserted mid-transaction returns the block to IDLE immediately. Any late `mem_ack` arriving while in IDLE is ignored.

## Timing
- Fetch latency: the request is issued on the cycle after IDLE samples `run`. `instr_valid` rises the cycle after `mem_ack`.
- With zero-wait memory (ack one cycle after request) and `instr_ready` tied high, throughput is one instruction per 3 cycles (REQ, ack/HOLD, reissue).
- `pc_enable` coincides with `mem_ack`. `pc_in` reflects the increment by the first HOLD cycle, so the HOLD-exit sample is always the next address.
- `flush` takes effect at the edge where it is sampled. No instruction captured from a flushed request is ever presented.

## Configuration
- `IFU_PERF_CNT_EN` defined: adds output `stall_cnt` [15:0]. Reset value is 0.
  - It increments on every cycle that is either REQ without `mem_ack`, or HOLD without `instr_ready`.
  - It saturates at 0xFFFF.
  - It clears when `flush` is sampled.
- `IFU_PERF_CNT_EN` not defined: no port and no counter logic. All other behaviour is identical.

## Test plan
- Basic fetch: release reset, `run` = 1, `pc_in` = 0x0000, memory returns 0xA5A5 with ack 1 cycle after request. Required: `mem_addr` = 0x0000, one `pc_enable` pulse, `instr_out` = 0xA5A5 with `instr_valid` high; the next request uses `mem_addr` = 0x0001.
- Wait states: ack delayed 4 cycles. Required: `mem_req` and `mem_addr` are stable for 4 cycles, exactly one `pc_enable` pulse, and `stall_cnt` = 4 when the macro is enabled.
- Back-pressure: `instr_ready` = 0 for 3 cycles in HOLD. Required: `instr_out` is held, no new `mem_req`, no `pc_enable`; fetch resumes the cycle after `instr_ready` = 1.
- Flush in flight: `flush` pulsed 1 cycle after the request to 0x0010, with ack arriving 2 cycles later carrying 0x1234. Required: `instr_valid` never rises, `pc_enable` = 0, and the state returns to IDLE.
- Wrap-around: `pc_in` = 0xFFFF. Required: fetch address 0xFFFF, then after `pc_enable` the next fetch address is 0x0000.
- Async reset mid-REQ: drive `reset` = 0 while waiting for ack. Required: `mem_req`, `instr_valid` and `pc_enable` go to 0 immediately, and a later stray `mem_ack` produces no `instr_valid` and no `pc_enable`.

Source files
------------

// File: rtl/instr_fetch_unit.sv
// -----------------------------------------------------------------------------
// instr_fetch_unit
//
// Purpose:
//   Consumer side of the program counter. The block samples the current PC,
//   reads the 16-bit instruction word at that address from instruction memory
//   and presents it to the decode stage. It also pulses pc_enable so that the
//   PC advances exactly once for every fetch whose data is accepted from memory.
//
// Handshakes:
//   Memory: mem_req rises together with a registered mem_addr. Both are held
//   until mem_ack, and a request is never withdrawn. mem_ack is a one-cycle
//   pulse, and mem_rdata is sampled in that cycle.
//   Decoder: instr_out and instr_valid are registered. While instr_valid is
//   high, instr_out is stable. A transfer completes on the rising edge where
//   both instr_valid and instr_ready are high.
//
// Ports:
//   clk          in   rising-edge clock
//   reset        in   asynchronous, active-low reset
//   run          in   fetch enable. The current transaction always completes.
//   flush        in   drops the instruction in flight or being held
//   pc_in        in   current PC from the program counter
//   pc_enable    out  PC increment strobe (combinational, one cycle per fetch)
//   mem_req      out  memory read request
//   mem_addr     out  memory read address (registered)
//   mem_ack      in   read data valid pulse
//   mem_rdata    in   read data
//   instr_out    out  fetched instruction (registered)
//   instr_valid  out  instr_out holds a valid instruction
//   instr_ready  in   the decoder accepts instr_out
//   stall_cnt    out  stall cycle counter (only when IFU_PERF_CNT_EN is defined)
//   dbg_state    out  current FSM state: 0 = IDLE, 1 = REQ, 2 = HOLD
//
// Build option:
//   IFU_PERF_CNT_EN  adds stall_cnt, a saturating 16-bit counter. It counts
//                    REQ cycles without mem_ack and HOLD cycles without
//                    instr_ready. Sampling flush clears it.
// -----------------------------------------------------------------------------
module instr_fetch_unit #(
    parameter int ADDR_W = 16,
    parameter int DATA_W = 16
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              run,
    input  logic              flush,
    input  logic [ADDR_W-1:0] pc_in,
    output logic              pc_enable,
    output logic              mem_req,
    output logic [ADDR_W-1:0] mem_addr,
    input  logic              mem_ack,
    input  logic [DATA_W-1:0] mem_rdata,
    output logic [DATA_W-1:0] instr_out,
    output logic              instr_valid,
    input  logic              instr_ready,
`ifdef IFU_PERF_CNT_EN
    output logic [15:0]       stall_cnt,
`endif
    output logic [1:0]        dbg_state
);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_REQ  = 2'd1,
        S_HOLD = 2'd2
    } state_t;

    state_t            r_state;
    logic              r_mem_req;
    logic [ADDR_W-1:0] r_mem_addr;
    logic [DATA_W-1:0] r_instr_out;
    logic              r_instr_valid;
    logic              r_discard;

    state_t            w_state_nxt;
    logic              w_mem_req_nxt;
    logic [ADDR_W-1:0] w_mem_addr_nxt;
    logic [DATA_W-1:0] w_instr_out_nxt;
    logic              w_instr_valid_nxt;
    logic              w_discard_nxt;
    logic              w_pc_enable;

    // State register
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_state       <= S_IDLE;
            r_mem_req     <= 1'b0;
            r_mem_addr    <= '0;
            r_instr_out   <= '0;
            r_instr_valid <= 1'b0;
            r_discard     <= 1'b0;
        end else begin
            r_state       <= w_state_nxt;
            r_mem_req     <= w_mem_req_nxt;
            r_mem_addr    <= w_mem_addr_nxt;
            r_instr_out   <= w_instr_out_nxt;
            r_instr_valid <= w_instr_valid_nxt;
            r_discard     <= w_discard_nxt;
        end
    end

    // Next-state and output logic
    always_comb begin
        w_state_nxt       = r_state;
        w_mem_req_nxt     = r_mem_req;
        w_mem_addr_nxt    = r_mem_addr;
        w_instr_out_nxt   = r_instr_out;
        w_instr_valid_nxt = r_instr_valid;
        w_discard_nxt     = r_discard;
        w_pc_enable       = 1'b0;

        unique case (r_state)
            S_IDLE: begin
                // A late mem_ack arriving here is ignored.
                if (run && !flush) begin
                    w_mem_addr_nxt = pc_in;
                    w_mem_req_nxt  = 1'b1;
                    w_state_nxt    = S_REQ;
                end
            end

            S_REQ: begin
                if (mem_ack) begin
                    w_mem_req_nxt = 1'b0;
                    if (r_discard || flush) begin
                        // The data belongs to a flushed fetch. It is dropped,
                        // and the PC is not advanced.
                        w_discard_nxt = 1'b0;
                        w_state_nxt   = S_IDLE;
                    end else begin
                        w_instr_out_nxt   = mem_rdata;
                        w_instr_valid_nxt = 1'b1;
                        w_pc_enable       = 1'b1;
                        w_state_nxt       = S_HOLD;
                    end
                end else if (flush) begin
                    // The request stays up until memory answers. The flush is
                    // remembered so that the answer is thrown away.
                    w_discard_nxt = 1'b1;
                end
            end

            S_HOLD: begin
                if (flush) begin
                    w_instr_valid_nxt = 1'b0;
                    w_state_nxt       = S_IDLE;
                end else if (instr_ready) begin
                    w_instr_valid_nxt = 1'b0;
                    if (run) begin
                        // pc_in already shows the incremented PC at this point.
                        w_mem_addr_nxt = pc_in;
                        w_mem_req_nxt  = 1'b1;
                        w_state_nxt    = S_REQ;
                    end else begin
                        w_state_nxt = S_IDLE;
                    end
                end
            end

            default: begin
                w_state_nxt       = S_IDLE;
                w_mem_req_nxt     = 1'b0;
                w_instr_valid_nxt = 1'b0;
                w_discard_nxt     = 1'b0;
            end
        endcase
    end

    assign pc_enable   = w_pc_enable;
    assign mem_req     = r_mem_req;
    assign mem_addr    = r_mem_addr;
    assign instr_out   = r_instr_out;
    assign instr_valid = r_instr_valid;
    assign dbg_state   = r_state;

`ifdef IFU_PERF_CNT_EN
    logic [15:0] r_stall_cnt;
    logic        w_stall;

    assign w_stall = ((r_state == S_REQ)  && !mem_ack) ||
                     ((r_state == S_HOLD) && !instr_ready);

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_stall_cnt <= 16'd0;
        end else if (flush) begin
            r_stall_cnt <= 16'd0;
        end else if (w_stall && (r_stall_cnt != 16'hFFFF)) begin
            r_stall_cnt <= r_stall_cnt + 16'd1;
        end
    end

    assign stall_cnt = r_stall_cnt;
`endif

endmodule

// File: tb/tb_instr_fetch_unit.sv
// -----------------------------------------------------------------------------
// tb_instr_fetch_unit
//
// Directed testbench for instr_fetch_unit. Inputs change 1 ns after each
// rising edge, and outputs are checked before the following falling edge.
// pe_cnt counts the pc_enable pulses, sampled on the falling edge.
// -----------------------------------------------------------------------------
module tb_instr_fetch_unit;

    localparam int ADDR_W = 16;
    localparam int DATA_W = 16;

    logic              clk;
    logic              reset;
    logic              run;
    logic              flush;
    logic [ADDR_W-1:0] pc_in;
    logic              pc_enable;
    logic              mem_req;
    logic [ADDR_W-1:0] mem_addr;
    logic              mem_ack;
    logic [DATA_W-1:0] mem_rdata;
    logic [DATA_W-1:0] instr_out;
    logic              instr_valid;
    logic              instr_ready;
    logic [1:0]        dbg_state;
`ifdef IFU_PERF_CNT_EN
    logic [15:0]       stall_cnt;
    logic [15:0]       stall_snap;
`endif

    int tests = 0;
    int fails = 0;
    int pe_cnt = 0;

    instr_fetch_unit #(.ADDR_W(ADDR_W), .DATA_W(DATA_W)) dut (
        .clk         (clk),
        .reset       (reset),
        .run         (run),
        .flush       (flush),
        .pc_in       (pc_in),
        .pc_enable   (pc_enable),
        .mem_req     (mem_req),
        .mem_addr    (mem_addr),
        .mem_ack     (mem_ack),
        .mem_rdata   (mem_rdata),
        .instr_out   (instr_out),
        .instr_valid (instr_valid),
        .instr_ready (instr_ready),
`ifdef IFU_PERF_CNT_EN
        .stall_cnt   (stall_cnt),
`endif
        .dbg_state   (dbg_state)
    );

    // Clock
    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Count pc_enable pulses
    always @(negedge clk) begin
        if (pc_enable === 1'b1) pe_cnt <= pe_cnt + 1;
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    initial begin
        reset       = 1'b0;
        run         = 1'b0;
        flush       = 1'b0;
        pc_in       = '0;
        mem_ack     = 1'b0;
        mem_rdata   = '0;
        instr_ready = 1'b0;

        // ---- reset state ----
        repeat (2) @(posedge clk);
        #1;
        chk("rst_mem_req",   32'(mem_req),     32'd0);
        chk("rst_valid",     32'(instr_valid), 32'd0);
        chk("rst_pc_enable", 32'(pc_enable),   32'd0);
        chk("rst_mem_addr",  32'(mem_addr),    32'd0);
        chk("rst_instr_out", 32'(instr_out),   32'd0);
        chk("rst_state",     32'(dbg_state),   32'd0);
`ifdef IFU_PERF_CNT_EN
        chk("rst_stall_cnt", 32'(stall_cnt),   32'd0);
`endif

        // ---- basic fetch from 0x0000 ----
        reset = 1'b1;
        run   = 1'b1;
        pc_in = 16'h0000;
        tick();                                  // IDLE -> REQ
        chk("b_mem_req",  32'(mem_req),   32'd1);
        chk("b_mem_addr", 32'(mem_addr),  32'h0000);
        chk("b_state",    32'(dbg_state), 32'd1);
        chk("b_pe_low",   32'(pc_enable), 32'd0);
        tick();                                  // ack one cycle after request
        mem_ack   = 1'b1;
        mem_rdata = 16'hA5A5;
        #1;
        chk("b_pe_ack",   32'(pc_enable), 32'd1);
        tick();                                  // REQ -> HOLD
        mem_ack = 1'b0;
        pc_in   = 16'h0001;
        #1;
        chk("b_valid",     32'(instr_valid), 32'd1);
        chk("b_instr_out", 32'(instr_out),   32'hA5A5);
        chk("b_req_off",   32'(mem_req),     32'd0);
        chk("b_pe_hold",   32'(pc_enable),   32'd0);
        chk("b_pe_cnt",    32'(pe_cnt),      32'd1);
        instr_ready = 1'b1;
        tick();                                  // HOLD -> REQ at the next PC
        chk("b_next_addr", 32'(mem_addr),    32'h0001);
        chk("b_next_req",  32'(mem_req),     32'd1);
        chk("b_valid_clr", 32'(instr_valid), 32'd0);
        instr_ready = 1'b0;

        // ---- wait states: ack four cycles after the request ----
`ifdef IFU_PERF_CNT_EN
        stall_snap = stall_cnt;
`endif
        for (int i = 0; i < 4; i++) begin
            chk("w_req_stable",  32'(mem_req),   32'd1);
            chk("w_addr_stable", 32'(mem_addr),  32'h0001);
            chk("w_pe_low",      32'(pc_enable), 32'd0);
            tick();
        end
`ifdef IFU_PERF_CNT_EN
        chk("w_stall_cnt", 32'(stall_cnt - stall_snap), 32'd4);
`endif
        mem_ack   = 1'b1;
        mem_rdata = 16'h0F0F;
        run       = 1'b0;                        // dropping run mid-REQ must not abort
        #1;
        chk("w_pe_ack", 32'(pc_enable), 32'd1);
        tick();                                  // REQ -> HOLD
        mem_ack = 1'b0;
        pc_in   = 16'h0002;
        run     = 1'b1;
        #1;
        chk("w_pe_cnt", 32'(pe_cnt), 32'd2);

        // ---- back-pressure: instr_ready low for three HOLD cycles ----
        for (int i = 0; i < 3; i++) begin
            chk("bp_valid", 32'(instr_valid), 32'd1);
            chk("bp_instr", 32'(instr_out),   32'h0F0F);
            chk("bp_noreq", 32'(mem_req),     32'd0);
            chk("bp_pe",    32'(pc_enable),   32'd0);
            chk("bp_state", 32'(dbg_state),   32'd2);
            tick();
        end
        instr_ready = 1'b1;
        #1;
        chk("bp_pe_ready", 32'(pc_enable), 32'd0);
        tick();                                  // fetch resumes
        chk("bp_resume_req",  32'(mem_req),  32'd1);
        chk("bp_resume_addr", 32'(mem_addr), 32'h0002);
        chk("bp_pe_cnt",      32'(pe_cnt),   32'd2);

        // Finish this fetch and let the block idle
        mem_ack   = 1'b1;
        mem_rdata = 16'h5555;
        run       = 1'b0;
        tick();                                  // REQ -> HOLD
        mem_ack = 1'b0;
        tick();                                  // HOLD -> IDLE (run low)
        chk("i_state",  32'(dbg_state), 32'd0);
        chk("i_pe_cnt", 32'(pe_cnt),    32'd3);

        // ---- flush while the request to 0x0010 is in flight ----
        pc_in = 16'h0010;
        run   = 1'b1;
        tick();                                  // IDLE -> REQ
        chk("f_addr", 32'(mem_addr), 32'h0010);
        run = 1'b0;
        tick();
        flush = 1'b1;                            // one cycle after the request
        #1;
        chk("f_pe_flush", 32'(pc_enable), 32'd0);
        tick();
        flush = 1'b0;
        #1;
        chk("f_valid_a", 32'(instr_valid), 32'd0);
        chk("f_state_a", 32'(dbg_state),   32'd1);
        chk("f_req_a",   32'(mem_req),     32'd1);
        tick();
        mem_ack   = 1'b1;                        // ack two cycles after the flush
        mem_rdata = 16'h1234;
        #1;
        chk("f_pe_ack", 32'(pc_enable), 32'd0);
        tick();
        mem_ack = 1'b0;
        #1;
        chk("f_state_idle", 32'(dbg_state),   32'd0);
        chk("f_valid_b",    32'(instr_valid), 32'd0);
        chk("f_req_off",    32'(mem_req),     32'd0);
        chk("f_pe_cnt",     32'(pe_cnt),      32'd3);
        tick();
        chk("f_valid_c", 32'(instr_valid), 32'd0);

        // ---- wrap-around at 0xFFFF ----
        pc_in = 16'hFFFF;
        run   = 1'b1;
        tick();                                  // IDLE -> REQ
        chk("wr_addr_ffff", 32'(mem_addr), 32'hFFFF);
        tick();
        mem_ack   = 1'b1;
        mem_rdata = 16'hBEEF;
        #1;
        chk("wr_pe", 32'(pc_enable), 32'd1);
        tick();                                  // REQ -> HOLD
        mem_ack = 1'b0;
        pc_in   = 16'h0000;
        #1;
        chk("wr_instr", 32'(instr_out),   32'hBEEF);
        chk("wr_valid", 32'(instr_valid), 32'd1);
        tick();                                  // HOLD -> REQ
        chk("wr_addr_0000", 32'(mem_addr), 32'h0000);
        chk("wr_req",       32'(mem_req),  32'd1);
        chk("wr_pe_cnt",    32'(pe_cnt),   32'd4);

        // ---- asynchronous reset while waiting for ack ----
        run = 1'b0;
        #2;
        reset = 1'b0;
        #1;
        chk("ar_req",   32'(mem_req),     32'd0);
        chk("ar_valid", 32'(instr_valid), 32'd0);
        chk("ar_pe",    32'(pc_enable),   32'd0);
        chk("ar_state", 32'(dbg_state),   32'd0);
        chk("ar_addr",  32'(mem_addr),    32'd0);
        tick();
        reset     = 1'b1;
        mem_ack   = 1'b1;                        // stray ack after reset
        mem_rdata = 16'h7777;
        #1;
        chk("ar_stray_pe", 32'(pc_enable), 32'd0);
        tick();
        mem_ack = 1'b0;
        #1;
        chk("ar_stray_valid", 32'(instr_valid), 32'd0);
        chk("ar_stray_req",   32'(mem_req),     32'd0);
        chk("ar_stray_state", 32'(dbg_state),   32'd0);
        chk("ar_pe_cnt",      32'(pe_cnt),      32'd4);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
